// File: rtl/instruction_fetch_stage.sv
// Fetch stage: program counter, combinational instruction-memory address and IF/ID register.
// Redirects that arrive while the pipeline is stalled are held until the stall releases.
module instruction_fetch_stage #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  system_clock,
    input  logic                  system_reset_n,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [31:0]           imem_data,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic [31:0]           pc,
    output logic                  if_id_valid,
    output logic [31:0]           if_id_instruction,
    output logic [31:0]           if_id_pc,
    output logic [31:0]           if_id_pc_plus4
);

    logic        pending_valid;
    logic [31:0] pending_pc;
    logic [31:0] aligned_redirect_pc;
    logic [31:0] target_pc;
    logic [31:0] pc_plus4;
    logic        take;

    assign aligned_redirect_pc = {redirect_pc[31:2], 2'b00};
    // A fresh redirect always wins over one parked during a stall.
    assign take      = redirect_valid | pending_valid;
    assign target_pc = redirect_valid ? aligned_redirect_pc : pending_pc;
    assign pc_plus4  = pc + 32'd4;

    assign imem_address = pc[ADDR_WIDTH+1:2];

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            pc                <= RESET_PC;
            pending_valid     <= 1'b0;
            pending_pc        <= 32'h0;
            if_id_valid       <= 1'b0;
            if_id_instruction <= 32'h0;
            if_id_pc          <= 32'h0;
            if_id_pc_plus4    <= 32'h0;
        end else if (stall) begin
            // Under stall a flush only kills the instruction; its pc fields stay put.
            if (flush) begin
                if_id_valid       <= 1'b0;
                if_id_instruction <= 32'h0;
            end
            if (redirect_valid) begin
                pending_valid <= 1'b1;
                pending_pc    <= aligned_redirect_pc;
            end
        end else if (take) begin
            pc                <= target_pc;
            pending_valid     <= 1'b0;
            if_id_valid       <= 1'b0;
            if_id_instruction <= 32'h0;
            if_id_pc          <= 32'h0;
            if_id_pc_plus4    <= 32'h0;
        end else begin
            pc <= pc_plus4;
            if (flush) begin
                if_id_valid       <= 1'b0;
                if_id_instruction <= 32'h0;
                if_id_pc          <= 32'h0;
                if_id_pc_plus4    <= 32'h0;
            end else begin
                if_id_valid       <= 1'b1;
                if_id_instruction <= imem_data;
                if_id_pc          <= pc;
                if_id_pc_plus4    <= pc_plus4;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: directed test-plan cases plus random traffic
// checked against a cycle-level reference model of the fetch rules.
module tb_instruction_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ifpc;
        logic [31:0] ifpc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  imem_address;
    logic [31:0] imem_data;
    logic        stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_instruction, if_id_pc, if_id_pc_plus4;

    logic [31:0] mem [0:1023];
    assign imem_data = mem[imem_address];

    always #5 clk = ~clk;

    instruction_fetch_stage #(.ADDR_WIDTH(10), .RESET_PC(32'h0)) dut (
        .system_clock     (clk),
        .system_reset_n   (rst_n),
        .imem_address     (imem_address),
        .imem_data        (imem_data),
        .stall            (stall),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .pc               (pc),
        .if_id_valid      (if_id_valid),
        .if_id_instruction(if_id_instruction),
        .if_id_pc         (if_id_pc),
        .if_id_pc_plus4   (if_id_pc_plus4)
    );

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    // reference model state
    logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_pend_pc;
    logic        m_valid, m_pend_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
        m_pend_v = 1'b0; m_pend_pc = 32'h0;
    endtask

    task automatic bubble_all();
        m_valid = 1'b0; m_instr = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
    endtask

    // One clock of the fetch rules, evaluated from the model's own state.
    task automatic model_edge(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
        logic [31:0] aligned;
        logic [31:0] fetched;
        aligned = rpc & 32'hFFFF_FFFC;
        fetched = mem[(m_pc >> 2) % 1024];
        if (st) begin
            if (fl) begin m_valid = 1'b0; m_instr = 32'h0; end
            if (rv) begin m_pend_v = 1'b1; m_pend_pc = aligned; end
        end else if (rv || m_pend_v) begin
            m_pc = rv ? aligned : m_pend_pc;
            m_pend_v = 1'b0;
            bubble_all();
        end else begin
            if (fl) bubble_all();
            else begin
                m_valid = 1'b1; m_instr = fetched; m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
            end
            m_pc = m_pc + 32'd4;
        end
    endtask

    // Drive one cycle of inputs, predict, then let the edge happen.
    task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
        exp_t e;
        stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
        model_edge(st, fl, rv, rpc);
        e.pc = m_pc; e.valid = m_valid; e.instr = m_instr; e.ifpc = m_ifpc; e.ifpc4 = m_ifpc4;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("imem_address", {22'h0, imem_address}, (e.pc >> 2) % 1024);
            chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.valid});
            chk("if_id_instruction", if_id_instruction, e.instr);
            chk("if_id_pc", if_id_pc, e.ifpc);
            chk("if_id_pc_plus4", if_id_pc_plus4, e.ifpc4);
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_imem_address"}, {22'h0, imem_address}, 32'h0);
        chk({tag, "_valid"}, {31'h0, if_id_valid}, 32'h0);
        chk({tag, "_instr"}, if_id_instruction, 32'h0);
        chk({tag, "_ifpc"}, if_id_pc, 32'h0);
        chk({tag, "_ifpc4"}, if_id_pc_plus4, 32'h0);
    endtask

    initial begin
        logic [31:0] held_pc, held_ifpc, held_instr;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0001; mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020; mem[3] = 32'h0000_0000;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        model_reset();
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;

        // free-running from reset
        step(0, 0, 0, 0);
        chk("first_ifpc", if_id_pc, 32'h0);
        chk("first_instr", if_id_instruction, 32'h2008_0001);
        chk("first_valid", {31'h0, if_id_valid}, 32'h1);
        step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        chk("pc_after_4", pc, 32'h10);

        // redirect from pc 0x8 to misaligned 0x43
        model_reset();
        rst_n = 1'b0; #1; rst_n = 1'b1;
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        chk("pc_is_8", pc, 32'h8);
        step(0, 0, 1, 32'h43);
        chk("redir_pc", pc, 32'h40);
        chk("redir_bubble", {31'h0, if_id_valid}, 32'h0);
        step(0, 0, 0, 0);
        chk("redir_ifpc", if_id_pc, 32'h40);
        chk("redir_ifpc4", if_id_pc_plus4, 32'h44);

        // redirect during a 3-cycle stall
        held_pc = pc; held_ifpc = if_id_pc; held_instr = if_id_instruction;
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h100);
        step(1, 0, 0, 0);
        chk("stall_pc", pc, held_pc);
        chk("stall_ifpc", if_id_pc, held_ifpc);
        chk("stall_instr", if_id_instruction, held_instr);
        step(0, 0, 0, 0);
        chk("pend_pc", pc, 32'h100);
        chk("pend_bubble", {31'h0, if_id_valid}, 32'h0);
        step(0, 0, 0, 0);
        chk("pend_target_ifpc", if_id_pc, 32'h100);

        // stall + flush with IF/ID valid at 0x20
        step(0, 0, 1, 32'h20);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("sf_valid", {31'h0, if_id_valid}, 32'h0);
        chk("sf_instr", if_id_instruction, 32'h0);
        chk("sf_ifpc", if_id_pc, 32'h20);
        chk("sf_pc", pc, 32'h24);

        // redirect and flush together: one bubble
        step(0, 1, 1, 32'h200);
        step(0, 0, 0, 0);
        chk("rf_ifpc", if_id_pc, 32'h200);
        chk("rf_valid", {31'h0, if_id_valid}, 32'h1);

        // pc wrap
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_ifpc4", if_id_pc_plus4, 32'h0);
        chk("wrap_pc", pc, 32'h0);

        // async reset mid-cycle with a pending redirect
        step(0, 0, 1, 32'h80);
        step(1, 0, 1, 32'h300);
        chk("pre_rst_pc", pc, 32'h80);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        #1 rst_n = 1'b1;
        step(0, 0, 0, 0);
        chk("post_rst_ifpc", if_id_pc, 32'h0);
        chk("post_rst_pc", pc, 32'h4);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic st, fl, rv;
            st = ($urandom_range(0, 9) < 3);
            fl = ($urandom_range(0, 9) < 2);
            rv = ($urandom_range(0, 19) < 3);
            step(st, fl, rv, $urandom);
        end

        @(posedge clk); #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
